// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- multiply/divide unit with architectural HI/LO registers.
//
// Accepts mult/multu/div/divu/mthi/mtlo commands from the R-type decode stage
// when en=1 and the unit is not busy. Multiplies hold busy for MULT_CYCLES
// cycles and divides for DIV_CYCLES cycles; the result is written to HI/LO on
// the same edge at which busy falls. mthi/mtlo write HI/LO on the next edge.
// A divide by zero runs the full duration but leaves HI/LO untouched.
//
// Ports
//   clk             : clock, rising edge active
//   reset_n         : asynchronous reset, active low
//   en              : a valid MD instruction is present this cycle
//   mult .. mflo    : one-hot function strobes (priority mult > multu > div >
//                     divu > mthi > mtlo when several are set)
//   rs_data/rt_data : 32-bit operands
//   busy            : registered, multiply/divide in progress
//   stall           : combinational, upstream must hold its MD instruction
//   hi/lo           : architectural HI and LO registers
//   rdata           : mfhi/mflo read data (mfhi wins), 0 when neither is set
// -----------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        mult,
    input  logic        multu,
    input  logic        div,
    input  logic        divu,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        mfhi,
    input  logic        mflo,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_t;

    // Two's-complement magnitude of a 32-bit value. 0x80000000 maps to itself,
    // which read as unsigned is exactly the magnitude we need.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // Two's-complement negation when neg is set.
    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    state_t            state_r;
    op_t               op_r;
    logic [31:0]       rs_r;
    logic [31:0]       rt_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       hi_r;
    logic [31:0]       lo_r;
    logic              busy_r;

    logic              start_s;
    op_t               start_op_s;
    logic              mthi_go_s;
    logic              mtlo_go_s;

    logic [63:0]       mul_a_s;
    logic [63:0]       mul_b_s;
    logic [63:0]       product_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [31:0]       dvd_mag_s;
    logic [31:0]       dvs_mag_s;
    logic [31:0]       dvs_safe_s;
    logic [31:0]       quot_mag_s;
    logic [31:0]       rem_mag_s;
    logic [31:0]       quot_s;
    logic [31:0]       rem_s;
    logic              div_by_zero_s;
    logic              is_mul_s;
    logic              result_we_s;
    logic [31:0]       res_hi_s;
    logic [31:0]       res_lo_s;
    logic [31:0]       rdata_s;

    // Command acceptance and strobe priority decode.
    always_comb begin
        start_s    = 1'b0;
        start_op_s = OP_MULT;
        mthi_go_s  = 1'b0;
        mtlo_go_s  = 1'b0;
        if (en && !busy_r) begin
            if (mult) begin
                start_s    = 1'b1;
                start_op_s = OP_MULT;
            end else if (multu) begin
                start_s    = 1'b1;
                start_op_s = OP_MULTU;
            end else if (div) begin
                start_s    = 1'b1;
                start_op_s = OP_DIV;
            end else if (divu) begin
                start_s    = 1'b1;
                start_op_s = OP_DIVU;
            end else if (mthi) begin
                mthi_go_s  = 1'b1;
            end else if (mtlo) begin
                mtlo_go_s  = 1'b1;
            end else begin
                start_s    = 1'b0;
            end
        end else begin
            start_s = 1'b0;
        end
    end

    // Result datapath from the latched operands. The multiply uses extended
    // 64-bit operands so a single unsigned multiplier serves both signednesses.
    // The signed divide goes through magnitudes so 0x80000000 / -1 wraps to
    // 0x80000000 instead of overflowing.
    always_comb begin
        is_mul_s      = (op_r == OP_MULT) || (op_r == OP_MULTU);
        if (op_r == OP_MULT) begin
            mul_a_s = {{32{rs_r[31]}}, rs_r};
            mul_b_s = {{32{rt_r[31]}}, rt_r};
        end else begin
            mul_a_s = {32'd0, rs_r};
            mul_b_s = {32'd0, rt_r};
        end
        product_s     = mul_a_s * mul_b_s;

        a_neg_s       = (op_r == OP_DIV) && rs_r[31];
        b_neg_s       = (op_r == OP_DIV) && rt_r[31];
        dvd_mag_s     = a_neg_s ? abs32(rs_r) : rs_r;
        dvs_mag_s     = b_neg_s ? abs32(rt_r) : rt_r;
        div_by_zero_s = (rt_r == 32'd0);
        // Keep the divider away from a zero divisor; that result is discarded.
        dvs_safe_s    = div_by_zero_s ? 32'd1 : dvs_mag_s;
        quot_mag_s    = dvd_mag_s / dvs_safe_s;
        rem_mag_s     = dvd_mag_s % dvs_safe_s;
        quot_s        = cond_neg32(quot_mag_s, a_neg_s ^ b_neg_s);
        rem_s         = cond_neg32(rem_mag_s, a_neg_s);

        result_we_s   = is_mul_s || !div_by_zero_s;

        case (op_r)
            OP_MULT, OP_MULTU: begin
                res_hi_s = product_s[63:32];
                res_lo_s = product_s[31:0];
            end
            OP_DIV, OP_DIVU: begin
                res_hi_s = rem_s;
                res_lo_s = quot_s;
            end
            default: begin
                res_hi_s = hi_r;
                res_lo_s = lo_r;
            end
        endcase
    end

    // Control FSM, cycle counter, operand latches and HI/LO registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            op_r    <= OP_MULT;
            rs_r    <= 32'd0;
            rt_r    <= 32'd0;
            cnt_r   <= CNT_ZERO;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        op_r    <= start_op_s;
                        rs_r    <= rs_data;
                        rt_r    <= rt_data;
                        if ((start_op_s == OP_MULT) || (start_op_s == OP_MULTU)) begin
                            cnt_r <= MULT_CNT;
                        end else begin
                            cnt_r <= DIV_CNT;
                        end
                    end else if (mthi_go_s) begin
                        hi_r <= rs_data;
                    end else if (mtlo_go_s) begin
                        lo_r <= rs_data;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    // Last busy cycle: drop busy and commit the result together.
                    if (cnt_r <= CNT_ONE) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= CNT_ZERO;
                        if (result_we_s) begin
                            hi_r <= res_hi_s;
                            lo_r <= res_lo_s;
                        end else begin
                            hi_r <= hi_r;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // mfhi/mflo read mux from the registered HI/LO.
    always_comb begin
        if (mfhi) begin
            rdata_s = hi_r;
        end else if (mflo) begin
            rdata_s = lo_r;
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign stall = en & busy_r & (mult | multu | div | divu | mthi | mtlo | mfhi | mflo);
    assign busy  = busy_r;
    assign hi    = hi_r;
    assign lo    = lo_r;
    assign rdata = rdata_s;

endmodule

// File: tb/tb_md_unit.sv
// -----------------------------------------------------------------------------
// tb_md_unit -- directed self-checking bench for md_unit (default parameters).
// -----------------------------------------------------------------------------
module tb_md_unit;

    localparam int C_MULT  = 0;
    localparam int C_MULTU = 1;
    localparam int C_DIV   = 2;
    localparam int C_DIVU  = 3;
    localparam int C_MTHI  = 4;
    localparam int C_MTLO  = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en, mult, multu, div, divu, mthi, mtlo, mfhi, mflo;
    logic [31:0] rs_data, rt_data;
    logic        busy, stall;
    logic [31:0] hi, lo, rdata;

    int tests = 0;
    int fails = 0;
    int n;
    int k;

    always #5 clk = ~clk;

    md_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .mult    (mult),
        .multu   (multu),
        .div     (div),
        .divu    (divu),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .mfhi    (mfhi),
        .mflo    (mflo),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo),
        .rdata   (rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b0; mult = 1'b0; multu = 1'b0; div = 1'b0; divu = 1'b0;
        mthi = 1'b0; mtlo = 1'b0; mfhi = 1'b0; mflo = 1'b0;
    endtask

    // Drive one command for one edge, then release the strobes.
    task automatic op(input int code, input logic [31:0] a, input logic [31:0] b);
        idle();
        en = 1'b1; rs_data = a; rt_data = b;
        case (code)
            C_MULT:  mult  = 1'b1;
            C_MULTU: multu = 1'b1;
            C_DIV:   div   = 1'b1;
            C_DIVU:  divu  = 1'b1;
            C_MTHI:  mthi  = 1'b1;
            default: mtlo  = 1'b1;
        endcase
        step();
        idle();
    endtask

    // Count sampled busy cycles, bounded so a stuck busy cannot hang the run.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rs_data = 32'd0; rt_data = 32'd0;
        reset_n = 1'b0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        step(); step();
        reset_n = 1'b1;
        step();

        // Signed multiply: -2 * 3 = -6
        op(C_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        chk("mult_busy_now", {31'd0, busy}, 32'd1);
        count_busy(n);
        chk("mult_busy_cycles", 32'(n), 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // Unsigned multiply: 0xFFFFFFFE * 3 = 0x2_FFFFFFFA
        op(C_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
        count_busy(n);
        chk("multu_busy_cycles", 32'(n), 32'd5);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        // Signed divide: -7 / 2 = -3 rem -1
        op(C_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        count_busy(n);
        chk("div_busy_cycles", 32'(n), 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // Overflow corner: 0x80000000 / -1
        op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0000_0000);

        // mthi writes next edge with no busy
        op(C_MTHI, 32'h1234_5678, 32'h0000_0000);
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_busy", {31'd0, busy}, 32'd0);

        // Unsigned divide by zero: full duration, HI/LO untouched
        op(C_DIVU, 32'h0000_0063, 32'h0000_0000);
        count_busy(n);
        chk("divu0_busy_cycles", 32'(n), 32'd10);
        chk("divu0_hi", hi, 32'h1234_5678);
        chk("divu0_lo", lo, 32'h8000_0000);

        // Unsigned divide: 100 / 7 = 14 rem 2
        op(C_DIVU, 32'd100, 32'd7);
        count_busy(n);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        op(C_MTLO, 32'hCAFE_F00D, 32'h0000_0000);
        chk("mtlo_lo", lo, 32'hCAFE_F00D);

        // Strobe with en=0 is ignored
        mult = 1'b1; rs_data = 32'd9; rt_data = 32'd9;
        step();
        chk("en0_busy", {31'd0, busy}, 32'd0);
        chk("en0_lo", lo, 32'hCAFE_F00D);
        idle();

        // mthi and mtlo together: mthi wins
        en = 1'b1; mthi = 1'b1; mtlo = 1'b1; rs_data = 32'h0000_0055;
        step();
        idle();
        chk("prio_hi", hi, 32'h0000_0055);
        chk("prio_lo", lo, 32'hCAFE_F00D);

        // Read mux
        mfhi = 1'b1; mflo = 1'b1; #1;
        chk("rdata_mfhi_prio", rdata, 32'h0000_0055);
        mfhi = 1'b0; #1;
        chk("rdata_mflo", rdata, 32'hCAFE_F00D);
        mflo = 1'b0; #1;
        chk("rdata_none", rdata, 32'h0000_0000);

        // mflo held during a multiply: stall every busy cycle, then new LO
        op(C_MULT, 32'd7, 32'd6);
        en = 1'b1; mflo = 1'b1; #1;
        k = 0;
        while (busy === 1'b1 && k < 40) begin
            chk("mflo_stall", {31'd0, stall}, 32'd1);
            k++;
            @(posedge clk); #2;
        end
        chk("mflo_busy_cycles", 32'(k), 32'd5);
        chk("mflo_stall_after", {31'd0, stall}, 32'd0);
        chk("mflo_rdata", rdata, 32'h0000_002A);
        idle();

        // mtlo held through a multiply: ignored while busy, accepted after
        op(C_MULT, 32'd2, 32'd3);
        en = 1'b1; mtlo = 1'b1; rs_data = 32'h0000_AAAA; #1;
        k = 0;
        while (busy === 1'b1 && k < 40) begin
            chk("busy_ignore_lo", lo, 32'h0000_002A);
            k++;
            @(posedge clk); #2;
        end
        chk("handoff_lo_product", lo, 32'h0000_0006);
        @(posedge clk); #2;
        chk("handoff_lo_mtlo", lo, 32'h0000_AAAA);
        chk("handoff_busy", {31'd0, busy}, 32'd0);
        idle();

        // Reset in cycle 3 of a multiply aborts it
        op(C_MTHI, 32'h0000_0077, 32'h0000_0000);
        op(C_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        step(); step();
        reset_n = 1'b0; #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        #3;
        reset_n = 1'b1;
        repeat (10) step();
        chk("rst_after_busy", {31'd0, busy}, 32'd0);
        chk("rst_after_hi", hi, 32'd0);
        chk("rst_after_lo", lo, 32'd0);
        op(C_MTLO, 32'h0000_1234, 32'h0000_0000);
        chk("rst_resume_lo", lo, 32'h0000_1234);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Parameters
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, which sets the busy duration in cycles for mult and multu.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, which sets the busy duration in cycles for div and divu.

Interface
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous reset, active-low.
REQ-005 SHALL have port en, input, 1 bit: the instruction is a valid R-type MD op this cycle.
REQ-006 SHALL have ports mult, multu, div, divu, mthi, mtlo, mfhi, mflo, each input, 1 bit: one-hot R-type function strobes from the R-type decode stage.
REQ-007 SHALL have ports rs_data and rt_data, each input, 32 bits: the operands.
REQ-008 SHALL have port busy, output, 1 bit: a registered signal meaning a multiply or divide is in progress.
REQ-009 SHALL have port stall, output, 1 bit: combinational; upstream must hold the current MD instruction.
REQ-010 SHALL have ports hi and lo, each output, 32 bits: the architectural HI and LO registers.
REQ-011 SHALL have port rdata, output, 32 bits: the mfhi/mflo read data.

Function
REQ-012 SHALL accept a command only when en=1 and busy=0; every strobe is ignored when en=0.
REQ-013 SHALL resolve multiple asserted strobes by the priority mult > multu > div > divu > mthi > mtlo.
REQ-014 SHALL implement two states: IDLE and RUN.
- IDLE -> RUN on an accepted mult, multu, div or divu.
- RUN -> IDLE when the cycle counter expires.
REQ-015 SHALL, on acceptance, latch both operands and the op type, and load the counter with MULT_CYCLES or DIV_CYCLES.
REQ-016 SHALL assert busy for exactly N consecutive cycles after the accept edge, where N is the loaded count.
REQ-017 SHALL write HI and LO on the same edge at which busy falls.
REQ-018 SHALL compute mult as the signed 64-bit product {HI,LO}, and multu as the unsigned 64-bit product.
REQ-019 SHALL compute div as signed, truncating toward zero: LO = quotient, HI = remainder, with the remainder taking the sign of the dividend.
REQ-020 SHALL compute divu as unsigned: LO = quotient, HI = remainder.
REQ-021 SHALL, for div 0x80000000 / 0xFFFFFFFF, produce LO = 0x80000000 and HI = 0x00000000.
REQ-022 SHALL, on divide by zero (div or divu), still run busy for DIV_CYCLES and leave HI and LO unchanged.
REQ-023 SHALL write rs_data to HI (mthi) or LO (mtlo) at the next edge when accepted; busy stays 0.
REQ-024 SHALL drive rdata = hi when mfhi=1, lo when mflo=1, and 0 otherwise, with mfhi taking priority; rdata is combinational from the registered HI/LO.
REQ-025 SHALL drive stall = en & busy & (any of the eight strobes).
REQ-026 SHALL ignore every strobe while busy=1: no HI/LO change and no restart.
REQ-027 SHALL, when en is asserted with an op on the cycle busy falls, see busy=1 and stall; the op is accepted on the following cycle.
REQ-028 SHALL update HI and LO only through REQ-017 or REQ-023; no other path writes them.

Reset
REQ-029 SHALL, on reset_n=0, immediately force: hi=0, lo=0, busy=0, counter=0, state IDLE.
REQ-030 SHALL, on reset_n=0 in RUN, abort the operation with no HI/LO write.
REQ-031 SHALL resume normal operation on the first rising clk edge after reset_n deasserts.

Verification
REQ-032 SHALL cover: mult with rs=0xFFFFFFFE, rt=0x00000003 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 SHALL cover: multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-034 SHALL cover: div with rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 SHALL cover: divu with rt=0 after mthi 0x12345678 -> busy 10 cycles, then HI=0x12345678 and LO unchanged.
REQ-036 SHALL cover: mflo issued during busy -> stall=1 on every busy cycle, then rdata equals the new LO on the cycle after busy falls.
REQ-037 SHALL cover: reset_n pulsed low at cycle 3 of a mult -> busy=0, hi=0, lo=0 immediately, and no later write occurs.
